// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer / occupancy controller for a storage-backed FIFO.
// The storage block owns the write pointer, read pointer and item count and
// feeds them back here; this block decides which requests are accepted,
// computes the values storage should load on the next edge, and keeps sticky
// error flags plus a high-water mark of occupancy.
module fifo_ctrl #(
  parameter int ADDR_BW   = 1,
  parameter int AFULL_LVL = 2**ADDR_BW - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_req,
  input  logic               pop_req,
  input  logic               flush,
  input  logic               err_clr,
  input  logic [ADDR_BW-1:0] wr_ptr,
  input  logic [ADDR_BW-1:0] rd_ptr,
  input  logic [ADDR_BW:0]   num_item,
  output logic               reg_push,
  output logic [ADDR_BW-1:0] next_wrptr,
  output logic [ADDR_BW-1:0] next_rdptr,
  output logic [ADDR_BW:0]   next_numitem,
  output logic               push_ack,
  output logic               pop_ack,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               ovf_err,
  output logic               udf_err,
  output logic               ptr_err,
  output logic [ADDR_BW:0]   peak_numitem
);

  localparam int               DEPTH     = 2**ADDR_BW;
  localparam logic [ADDR_BW:0] DEPTH_CNT = DEPTH[ADDR_BW:0];

  logic               ovf_set;
  logic               udf_set;
  logic               ptr_set;
  logic [ADDR_BW-1:0] ptr_diff;

  // Status flags are purely a function of the fed-back occupancy.
  assign full        = (num_item == DEPTH_CNT);
  assign empty       = (num_item == '0);
  assign almost_full = (int'(num_item) >= AFULL_LVL);

  // Request acceptance and next pointer/occupancy; reset and flush force all
  // of it to zero, and a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if-tree can leave it unassigned and infer a latch.
    pop_ack      = 1'b0;
    push_ack     = 1'b0;
    reg_push     = 1'b0;
    next_wrptr   = '0;
    next_rdptr   = '0;
    next_numitem = '0;
    if (rst && !flush) begin
      pop_ack      = pop_req && !empty;
      push_ack     = push_req && (!full || pop_ack);
      reg_push     = push_ack;
      // Pointer adds are ADDR_BW wide, so wrap to 0 past the last slot is free.
      next_wrptr   = wr_ptr + ADDR_BW'(push_ack);
      next_rdptr   = rd_ptr + ADDR_BW'(pop_ack);
      next_numitem = num_item + (ADDR_BW+1)'(push_ack) - (ADDR_BW+1)'(pop_ack);
    end
  end

  // Error conditions for this cycle; a flush drops requests silently.
  assign ovf_set  = push_req && !push_ack && !flush;
  assign udf_set  = pop_req && !pop_ack && !flush;
  assign ptr_diff = wr_ptr - rd_ptr;
  assign ptr_set  = (ptr_diff != num_item[ADDR_BW-1:0]);

  // Sticky error flags and occupancy high-water mark; a new error in the
  // same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      ovf_err      <= 1'b0;
      udf_err      <= 1'b0;
      ptr_err      <= 1'b0;
      peak_numitem <= '0;
    end else begin
      ovf_err <= ovf_set || (ovf_err && !err_clr);
      udf_err <= udf_set || (udf_err && !err_clr);
      ptr_err <= ptr_set || (ptr_err && !err_clr);
      if (num_item > peak_numitem) begin
        peak_numitem <= num_item;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl (ADDR_BW=2, depth 4, almost_full at 3).
// The bench plays the storage role: it holds wr_ptr/rd_ptr/num_item and loads
// them from the DUT's next_* outputs each edge, or forces them directly.
module tb_fifo_ctrl;

  localparam int             AW      = 2;
  localparam logic [AW:0]    DEPTH_V = 3'd4;
  localparam logic [AW:0]    AFULL_V = 3'd3;

  logic          clk;
  logic          rst;
  logic          push_req;
  logic          pop_req;
  logic          flush;
  logic          err_clr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   num_item;
  logic          reg_push;
  logic [AW-1:0] next_wrptr;
  logic [AW-1:0] next_rdptr;
  logic [AW:0]   next_numitem;
  logic          push_ack;
  logic          pop_ack;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          ovf_err;
  logic          udf_err;
  logic          ptr_err;
  logic [AW:0]   peak_numitem;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          rst, push, pop, flush;
    logic [AW-1:0] wr, rd;
    logic [AW:0]   num;
    logic          pa, qa;
    logic [AW-1:0] nwr, nrd;
    logic [AW:0]   nnum;
    logic          f, e, af;
  } vec_t;

  typedef struct {
    logic        ovf, udf, ptr;
    logic [AW:0] peak;
  } flag_t;

  flag_t       sb_q[$];
  logic        m_ovf, m_udf, m_ptr;
  logic [AW:0] m_peak;
  vec_t        tbl[12];

  fifo_ctrl #(.ADDR_BW(AW)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req),
    .flush(flush), .err_clr(err_clr), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .num_item(num_item), .reg_push(reg_push), .next_wrptr(next_wrptr),
    .next_rdptr(next_rdptr), .next_numitem(next_numitem),
    .push_ack(push_ack), .pop_ack(pop_ack), .full(full), .empty(empty),
    .almost_full(almost_full), .ovf_err(ovf_err), .udf_err(udf_err),
    .ptr_err(ptr_err), .peak_numitem(peak_numitem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, p, q, f, input int w, rp, n, input logic pa, qa,
                              input int nw, nr, nn, input logic fu, em, af);
    vec_t v;
    v.rst = r;  v.push = p; v.pop = q; v.flush = f;
    v.wr = AW'(w); v.rd = AW'(rp); v.num = (AW+1)'(n);
    v.pa = pa; v.qa = qa;
    v.nwr = AW'(nw); v.nrd = AW'(nr); v.nnum = (AW+1)'(nn);
    v.f = fu; v.e = em; v.af = af;
    return v;
  endfunction

  // One clock of operation: drive, check combinational outputs against the
  // model, queue the expected registered state, then compare it after the edge.
  task automatic step(input logic r, p, q, f, c);
    logic          e_pa, e_qa;
    logic [AW-1:0] e_wr, e_rd, d;
    logic [AW:0]   e_num;
    logic [AW-1:0] s_wr, s_rd;
    logic [AW:0]   s_num;
    flag_t         ef, got;
    rst = r; push_req = p; pop_req = q; flush = f; err_clr = c;
    #1;
    e_qa = q && (num_item != 0) && !f && r;
    e_pa = p && ((num_item != DEPTH_V) || e_qa) && !f && r;
    if (r && !f) begin
      e_wr  = wr_ptr + AW'(e_pa);
      e_rd  = rd_ptr + AW'(e_qa);
      e_num = num_item + (AW+1)'(e_pa) - (AW+1)'(e_qa);
    end else begin
      e_wr = '0; e_rd = '0; e_num = '0;
    end
    check("push_ack", push_ack, e_pa);
    check("pop_ack", pop_ack, e_qa);
    check("reg_push", reg_push, e_pa);
    check("next_wrptr", next_wrptr, e_wr);
    check("next_rdptr", next_rdptr, e_rd);
    check("next_numitem", next_numitem, e_num);
    check("full", full, num_item == DEPTH_V);
    check("empty", empty, num_item == 0);
    check("almost_full", almost_full, num_item >= AFULL_V);
    d = wr_ptr - rd_ptr;
    if (!r) begin
      ef.ovf = 1'b0; ef.udf = 1'b0; ef.ptr = 1'b0; ef.peak = '0;
    end else begin
      ef.ovf  = (p && !e_pa && !f) || (m_ovf && !c);
      ef.udf  = (q && !e_qa && !f) || (m_udf && !c);
      ef.ptr  = (d != num_item[AW-1:0]) || (m_ptr && !c);
      ef.peak = (num_item > m_peak) ? num_item : m_peak;
    end
    sb_q.push_back(ef);
    m_ovf = ef.ovf; m_udf = ef.udf; m_ptr = ef.ptr; m_peak = ef.peak;
    s_wr = next_wrptr; s_rd = next_rdptr; s_num = next_numitem;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard underrun", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check("ovf_err", ovf_err, got.ovf);
      check("udf_err", udf_err, got.udf);
      check("ptr_err", ptr_err, got.ptr);
      check("peak_numitem", peak_numitem, got.peak);
    end
    wr_ptr = s_wr; rd_ptr = s_rd; num_item = s_num;
  endtask

  initial begin
    rst = 1'b0; push_req = 1'b0; pop_req = 1'b0; flush = 1'b0; err_clr = 1'b0;
    wr_ptr = '0; rd_ptr = '0; num_item = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_ptr = 1'b0; m_peak = '0;

    //            rst push pop flush wr rd num  pa qa nwr nrd nn  full empty af
    tbl[0]  = mk(1'b0,1'b1,1'b1,1'b0, 2, 1, 1, 1'b0,1'b0, 0, 0, 0, 1'b0,1'b0,1'b0);
    tbl[1]  = mk(1'b1,1'b1,1'b0,1'b0, 0, 0, 0, 1'b1,1'b0, 1, 0, 1, 1'b0,1'b1,1'b0);
    tbl[2]  = mk(1'b1,1'b0,1'b1,1'b0, 0, 0, 0, 1'b0,1'b0, 0, 0, 0, 1'b0,1'b1,1'b0);
    tbl[3]  = mk(1'b1,1'b1,1'b1,1'b0, 0, 0, 0, 1'b1,1'b0, 1, 0, 1, 1'b0,1'b1,1'b0);
    tbl[4]  = mk(1'b1,1'b1,1'b0,1'b0, 3, 3, 0, 1'b1,1'b0, 0, 3, 1, 1'b0,1'b1,1'b0);
    tbl[5]  = mk(1'b1,1'b1,1'b0,1'b0, 0, 0, 4, 1'b0,1'b0, 0, 0, 4, 1'b1,1'b0,1'b1);
    tbl[6]  = mk(1'b1,1'b1,1'b1,1'b0, 1, 1, 4, 1'b1,1'b1, 2, 2, 4, 1'b1,1'b0,1'b1);
    tbl[7]  = mk(1'b1,1'b0,1'b1,1'b0, 1, 3, 2, 1'b0,1'b1, 1, 0, 1, 1'b0,1'b0,1'b0);
    tbl[8]  = mk(1'b1,1'b1,1'b0,1'b0, 3, 0, 3, 1'b1,1'b0, 0, 0, 4, 1'b0,1'b0,1'b1);
    tbl[9]  = mk(1'b1,1'b1,1'b1,1'b1, 2, 0, 2, 1'b0,1'b0, 0, 0, 0, 1'b0,1'b0,1'b0);
    tbl[10] = mk(1'b0,1'b1,1'b0,1'b1, 3, 1, 2, 1'b0,1'b0, 0, 0, 0, 1'b0,1'b0,1'b0);
    tbl[11] = mk(1'b1,1'b1,1'b1,1'b0, 2, 0, 2, 1'b1,1'b1, 3, 1, 2, 1'b0,1'b0,1'b0);

    // Combinational vectors: inputs held static, outputs compared after settling.
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; push_req = tbl[i].push; pop_req = tbl[i].pop;
      flush = tbl[i].flush; err_clr = 1'b0;
      wr_ptr = tbl[i].wr; rd_ptr = tbl[i].rd; num_item = tbl[i].num;
      #1;
      check($sformatf("vec%0d push_ack", i), push_ack, tbl[i].pa);
      check($sformatf("vec%0d pop_ack", i), pop_ack, tbl[i].qa);
      check($sformatf("vec%0d reg_push", i), reg_push, tbl[i].pa);
      check($sformatf("vec%0d next_wrptr", i), next_wrptr, tbl[i].nwr);
      check($sformatf("vec%0d next_rdptr", i), next_rdptr, tbl[i].nrd);
      check($sformatf("vec%0d next_numitem", i), next_numitem, tbl[i].nnum);
      check($sformatf("vec%0d full", i), full, tbl[i].f);
      check($sformatf("vec%0d empty", i), empty, tbl[i].e);
      check($sformatf("vec%0d almost_full", i), almost_full, tbl[i].af);
    end
    wr_ptr = '0; rd_ptr = '0; num_item = '0;
    @(negedge clk);

    // Reset with a push pending: request dropped, flags and peak cleared.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset ovf_err", ovf_err, 1'b0);
    check("reset peak", peak_numitem, 0);

    // Four pushes fill the FIFO; write pointer wraps 3 -> 0.
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("num_item after push %0d", k), num_item, k);
    end
    #1;
    check("full after 4 pushes", full, 1'b1);
    check("wr_ptr wrapped", wr_ptr, 0);

    // Overflow on a fifth push; set beats err_clr; then err_clr clears.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovf after 5th push", ovf_err, 1'b1);
    check("num_item held at 4", num_item, 4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ovf set wins over err_clr", ovf_err, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf cleared", ovf_err, 1'b0);

    // Full with push and pop together: both accepted, pointers advance.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("full push+pop wr_ptr", wr_ptr, 1);
    check("full push+pop rd_ptr", rd_ptr, 1);
    check("full push+pop num_item", num_item, 4);

    // Drain, then push+pop on empty: pop rejected, underflow flagged.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("drained", num_item, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("empty push+pop num_item", num_item, 1);
    check("udf after empty pop", udf_err, 1'b1);

    // From reset: three pushes, then flush with a push request.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush num_item", num_item, 0);
    check("flush wr_ptr", wr_ptr, 0);
    check("flush ovf_err", ovf_err, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("peak kept across flush", peak_numitem, 3);

    // Inconsistent feedback: count 2 with equal pointers -> ptr_err; reset clears.
    wr_ptr = 2'd1; rd_ptr = 2'd1; num_item = 3'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ptr_err on mismatch", ptr_err, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ptr_err after reset", ptr_err, 1'b0);
    check("peak after reset", peak_numitem, 0);

    // Random traffic with occasional flush, err_clr and reset.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(63) != 0), $urandom_range(1) == 1, $urandom_range(1) == 1,
           ($urandom_range(15) == 0), ($urandom_range(15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
